// File: rtl/dmem_responder.sv
// Data-memory responder for the core's MEM stage: one load/store at a time over
// valid/ready, RV32I store lanes, raw aligned word on loads, programmable wait states.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              load_ok_q, load_ok_d;

  logic              accept;
  logic              enter_resp;
  logic              cur_we;
  logic [2:0]        cur_funct3;
  logic [31:0]       cur_addr;
  logic [31:0]       cur_wdata;
  logic              range_err;
  logic              funct3_err;
  logic              align_err;
  logic              cur_err;
  logic [3:0]        lane_mask;
  logic [31:0]       lane_data;
  logic [ADDR_W-1:0] word_idx;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       rd_word;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // With LATENCY=0 the response state is entered on the accept edge itself,
  // so the decode must look at the live request rather than the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we     = req_we;
      cur_funct3 = req_funct3;
      cur_addr   = req_addr;
      cur_wdata  = req_wdata;
    end else begin
      cur_we     = we_q;
      cur_funct3 = funct3_q;
      cur_addr   = addr_q;
      cur_wdata  = wdata_q;
    end
  end

  always_comb begin
    range_err = (cur_addr >> (ADDR_W + 2)) != 32'd0;
    if (cur_we) begin
      funct3_err = !(cur_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      funct3_err = !(cur_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    align_err = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    cur_err  = range_err || funct3_err || align_err;
    word_idx = cur_addr[ADDR_W+1:2];
    case (cur_funct3[1:0])
      2'b00: begin
        lane_mask = 4'b0001 << cur_addr[1:0];
        lane_data = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = cur_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{cur_wdata[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        lane_data = cur_wdata;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    load_ok_d  = load_ok_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d   = IDLE;
          err_d     = 1'b0;
          load_ok_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      err_d     = cur_err;
      load_ok_d = !cur_we && !cur_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      load_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      load_ok_q <= load_ok_d;
    end
  end

  // Storage has no reset, so the commit must be blocked explicitly while reset is high.
  assign mem_we = enter_resp && cur_we && !cur_err && !reset;
  assign mem_re = enter_resp && !cur_we && !reset;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (mem_we && lane_mask[gi]) begin
        mem[word_idx] <= lane_data[gi*8 +: 8];
      end
      if (mem_re) begin
        rd_q <= mem[word_idx];
      end
    end

    assign rd_word[gi*8 +: 8] = rd_q;
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;
  assign rsp_rdata = load_ok_q ? rd_word : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: a LATENCY=2 instance for timing,
// lanes, errors, backpressure and reset; a LATENCY=0 instance for back-to-back traffic.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [2:0]  a_req_funct3;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;

  dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } breq_t;

  exp_t  a_exp[$];
  exp_t  b_exp[$];
  breq_t b_tab[7];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction on instance A; hold = cycles rsp_ready stays low once the response is up.
  task automatic req_a(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int   k;
    exp_t e;
    @(negedge clk);
    a_req_we     = we;
    a_req_funct3 = f3;
    a_req_addr   = addr;
    a_req_wdata  = wdata;
    a_req_valid  = 1'b1;
    a_rsp_ready  = (hold == 0);
    chk({tag, ".ready"}, 32'(a_req_ready), 32'd1);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    a_exp.push_back(e);
    @(negedge clk);
    a_req_valid  = 1'b0;
    a_req_we     = ~we;
    a_req_funct3 = 3'($urandom);
    a_req_addr   = $urandom;
    a_req_wdata  = $urandom;
    k = 1;
    while (!a_rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".lat"}, 32'(k), 32'd3);
    e = a_exp.pop_front();
    chk({tag, ".rdata"}, a_rsp_rdata, e.rdata);
    chk({tag, ".err"}, 32'(a_rsp_err), 32'(e.err));
    $display("txn A %s we=%0d f3=%0d addr=%08h lat=%0d rdata=%08h err=%0d",
             tag, we, f3, addr, k, a_rsp_rdata, a_rsp_err);
    for (int i = 0; i < hold; i++) begin
      a_req_valid  = 1'b1;
      a_req_we     = 1'b1;
      a_req_funct3 = 3'b010;
      a_req_addr   = 32'h10;
      a_req_wdata  = 32'h0;
      chk({tag, ".hold_valid"}, 32'(a_rsp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, a_rsp_rdata, e.rdata);
      chk({tag, ".hold_err"}, 32'(a_rsp_err), 32'(e.err));
      chk({tag, ".hold_ready"}, 32'(a_req_ready), 32'd0);
      @(negedge clk);
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".post_valid"}, 32'(a_rsp_valid), 32'd0);
    chk({tag, ".post_ready"}, 32'(a_req_ready), 32'd1);
    chk({tag, ".post_rdata"}, a_rsp_rdata, 32'd0);
    chk({tag, ".post_err"}, 32'(a_rsp_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int   idx;
    int   last;
    exp_t e;
    reset = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_funct3 = 3'b0; a_req_addr = 32'h0;
    a_req_wdata = 32'h0; a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_funct3 = 3'b0; b_req_addr = 32'h0;
    b_req_wdata = 32'h0; b_rsp_ready = 1'b1;
    b_tab[0] = {1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0,        1'b0};
    b_tab[1] = {1'b0, 3'b010, 32'h40, 32'h0,        32'hCAFEF00D, 1'b0};
    b_tab[2] = {1'b1, 3'b000, 32'h43, 32'h00000077, 32'h0,        1'b0};
    b_tab[3] = {1'b0, 3'b010, 32'h40, 32'h0,        32'h77FEF00D, 1'b0};
    b_tab[4] = {1'b0, 3'b001, 32'h41, 32'h0,        32'h0,        1'b1};
    b_tab[5] = {1'b1, 3'b001, 32'h42, 32'h00009ABC, 32'h0,        1'b0};
    b_tab[6] = {1'b0, 3'b010, 32'h40, 32'h0,        32'h9ABCF00D, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst.a_ready", 32'(a_req_ready), 32'd0);
    chk("rst.b_ready", 32'(b_req_ready), 32'd0);
    chk("rst.a_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst.a_rdata", a_rsp_rdata, 32'd0);
    chk("rst.a_err", 32'(a_rsp_err), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst.a_ready_rel", 32'(a_req_ready), 32'd1);

    req_a("sw10",   1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 0);
    req_a("lw10",   1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 0);
    req_a("sb12",   1'b1, 3'b000, 32'h12, 32'h000000AA, 32'h0,        1'b0, 0);
    req_a("sh10",   1'b1, 3'b001, 32'h10, 32'h00001234, 32'h0,        1'b0, 0);
    req_a("lw10b",  1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAA1234, 1'b0, 0);
    req_a("sw14",   1'b1, 3'b010, 32'h14, 32'h01234567, 32'h0,        1'b0, 0);
    req_a("sh16",   1'b1, 3'b001, 32'h16, 32'h0000ABCD, 32'h0,        1'b0, 0);
    req_a("sb15",   1'b1, 3'b000, 32'h15, 32'h00000099, 32'h0,        1'b0, 0);
    req_a("lw14",   1'b0, 3'b010, 32'h14, 32'h0,        32'hABCD9967, 1'b0, 0);
    req_a("lh11",   1'b0, 3'b001, 32'h11, 32'h0,        32'h0,        1'b1, 0);
    req_a("sw12",   1'b1, 3'b010, 32'h12, 32'hFFFFFFFF, 32'h0,        1'b1, 0);
    req_a("sbu10",  1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b1, 0);
    req_a("lw10c",  1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAA1234, 1'b0, 0);
    req_a("f3_011", 1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 0);
    req_a("lw1000", 1'b0, 3'b010, 32'h1000, 32'h0,      32'h0,        1'b1, 0);
    req_a("lbu13",  1'b0, 3'b100, 32'h13, 32'h0,        32'hDEAA1234, 1'b0, 0);
    req_a("lhu12",  1'b0, 3'b101, 32'h12, 32'h0,        32'hDEAA1234, 1'b0, 0);
    req_a("bp_lw",  1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAA1234, 1'b0, 5);
    req_a("lw10d",  1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAA1234, 1'b0, 0);

    idx  = 0;
    last = -10;
    for (int cyc = 0; cyc < 60 && !(idx == 7 && b_exp.size() == 0); cyc++) begin
      @(negedge clk);
      if (cyc == last + 1) chk("b.lat", 32'(b_rsp_valid), 32'd1);
      if (b_rsp_valid) begin
        if (b_exp.size() > 0) begin
          e = b_exp.pop_front();
          chk("b.rdata", b_rsp_rdata, e.rdata);
          chk("b.err", 32'(b_rsp_err), 32'(e.err));
          $display("txn B cyc=%0d rdata=%08h err=%0d", cyc, b_rsp_rdata, b_rsp_err);
        end else begin
          chk("b.spurious_rsp", 32'(b_rsp_valid), 32'd0);
        end
      end
      if (idx < 7) begin
        b_req_we     = b_tab[idx].we;
        b_req_funct3 = b_tab[idx].f3;
        b_req_addr   = b_tab[idx].addr;
        b_req_wdata  = b_tab[idx].wdata;
        b_req_valid  = 1'b1;
        if (b_req_ready) begin
          e.rdata = b_tab[idx].rdata;
          e.err   = b_tab[idx].err;
          b_exp.push_back(e);
          if (idx > 0) chk("b.spacing", 32'(cyc - last), 32'd2);
          last = cyc;
          idx++;
        end
      end else begin
        b_req_valid = 1'b0;
      end
    end
    b_req_valid = 1'b0;
    chk("b.accepted", 32'(idx), 32'd7);
    chk("b.drained", 32'(b_exp.size()), 32'd0);

    req_a("sw20", 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0, 0);
    @(negedge clk);
    a_req_we = 1'b1; a_req_funct3 = 3'b010; a_req_addr = 32'h20;
    a_req_wdata = 32'h55555555; a_req_valid = 1'b1;
    chk("mid.ready", 32'(a_req_ready), 32'd1);
    @(negedge clk);
    a_req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid.ready_in_rst", 32'(a_req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid.valid_after", 32'(a_rsp_valid), 32'd0);
    chk("mid.ready_after", 32'(a_req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid.no_rsp", 32'(a_rsp_valid), 32'd0);
    end
    $display("txn A mid-reset sw20 abandoned");
    req_a("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h11223344, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target for the pipeline core's MEM stage. It sits at the responding end of the load/store port.
- Accepts one load/store request at a time over a valid/ready handshake. Applies RV32I byte/halfword/word write lanes from funct3 and address.
- Returns the raw aligned 32-bit word. Sign/zero extension stays in the core's load-type logic.
- Inserts a programmable number of wait states, so the core's stall path is exercised against a non-ideal memory.

Parameters:
- ADDR_W, 10, word-address width; storage DEPTH = 2**ADDR_W 32-bit words.
- LATENCY, 2, wait-state cycles between request acceptance and response (0 legal).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/halfword is significant for SB/SH.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  aligned word read (loads); 0 for stores and errors.
- rsp_err  out  1  request rejected: misaligned, out of range or illegal funct3.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, reset).
- FSM states: IDLE, WAIT, RESP.
- On reset: state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- While reset is high, req_ready=0. Storage array is not cleared.
- req_ready = (state==IDLE) && !reset.
- Request is accepted on an edge where req_valid && req_ready. All request fields are latched at that edge; later changes are ignored.
- Accept with LATENCY>0: go to WAIT, counter=LATENCY-1. WAIT decrements each cycle; at 0, go to RESP.
- Accept with LATENCY=0: go directly to RESP.
- rsp_valid first rises LATENCY+1 cycles after the accept edge.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are stable until an edge with rsp_ready=1; then go to IDLE and clear rsp_valid, rsp_rdata and rsp_err to 0.
- No request is accepted in the response-handshake cycle. Minimum request spacing is LATENCY+2 cycles.
- Word index = latched addr[ADDR_W+1:2]. Any nonzero addr[31:ADDR_W+2] is out of range and sets err.
- Legal loads: funct3 000, 001, 010, 100, 101. Legal stores: 000, 001, 010. Any other funct3 sets err.
- Misaligned, sets err:
  - funct3[1:0]=01 with addr[0]=1.
  - funct3[1:0]=10 with addr[1:0]!=00.
- Store byte-lane mask:
  - SB: 1<<addr[1:0], data = wdata[7:0] replicated to all 4 bytes.
  - SH: 0011 if addr[1]=0 else 1100, data = wdata[15:0] replicated to both halves.
  - SW: 1111, data = wdata.
- Store commit happens on the edge entering RESP, only enabled lanes are written, and only if err=0. An errored store writes nothing.
- Load: rsp_rdata = full word at the word index, read on the edge entering RESP, so it reflects all prior committed stores. Errored load returns 0.
- Stores always return rsp_rdata=0.
- Reset during WAIT or RESP: the transaction is abandoned and a pending store is not committed. Next cycle, rsp_valid=0, and req_ready=1 once reset is low.
- rsp_ready held low: stay in RESP indefinitely, outputs unchanged, and req_ready stays 0.
- req_valid high outside IDLE: ignored, not queued.

Test Plan:
1. LATENCY=2. SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → store response rsp_err=0, rsp_rdata=0. Load rsp_rdata=0xDEADBEEF, rsp_valid rising exactly 3 cycles after each accept.
2. After scenario 1: SB addr 0x12 data 0x000000AA, then SH addr 0x10 data 0x00001234, then LW 0x10 → rsp_rdata=0xDEAA1234.
3. Errors:
   - LH 0x11 → err=1, rdata=0.
   - SW 0x12 data 0xFFFFFFFF → err=1, and a following LW 0x10 still reads 0xDEAA1234.
   - funct3=011 → err=1.
   - LW 0x00001000 with ADDR_W=10 → err=1.
4. Backpressure: hold rsp_ready=0 for 5 cycles during an LW response → rsp_valid, rsp_rdata and rsp_err stay constant and req_ready=0 throughout. After rsp_ready=1, req_ready=1 on the following cycle.
5. LATENCY=0: LW accepted at edge N → rsp_valid=1 after edge N+1. Back-to-back requests with rsp_ready=1 tied high are accepted every 2 cycles.
6. Reset mid-operation: SW 0x20 data 0x55555555, assert reset one cycle after accept, then LW 0x20 → rsp_valid=0 the cycle after reset. Load returns the pre-store word (store never committed).
